// File: rtl/neuron_pkg.sv
// Shared widths, label/class encodings and stage-valid type for the neuron classifier.
package neuron_pkg;

    localparam int X_W    = 7;
    localparam int W_W    = 14;
    localparam int T_W    = 2;
    localparam int PROD_W = 21;
    localparam int SUM_W  = 22;

    localparam logic [T_W-1:0] POS = 2'b01;
    localparam logic [T_W-1:0] NEG = 2'b11;

    // Bit 0 = stage 1 (products), bit 1 = stage 2 (output register)
    typedef logic [1:0] stage_vld_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Clear wins over increment; increment stops at the maximum value
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/neuron_classifier.sv
// Two-stage perceptron inference pipeline: y = (w1*x1 + w2*x2)/16 + b, class sign,
// label mismatch flag and saturating sample/error counters, with valid/ready on both sides.
module neuron_classifier
    import neuron_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ldWeights,
    input  logic signed [W_W-1:0]   w1In,
    input  logic signed [W_W-1:0]   w2In,
    input  logic signed [W_W-1:0]   bIn,
    input  logic                    cntClear,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic signed [X_W-1:0]   x1,
    input  logic signed [X_W-1:0]   x2,
    input  logic signed [T_W-1:0]   t,
    output logic                    outValid,
    input  logic                    outReady,
    output logic signed [W_W-1:0]   y,
    output logic signed [T_W-1:0]   cls,
    output logic                    mismatch,
    output logic [CNT_W-1:0]        sampleCount,
    output logic [CNT_W-1:0]        errorCount,
    output logic                    busy
);

    // Signed divide by 16 rounding toward zero: bias negatives by 15 before the arithmetic shift
    function automatic logic signed [SUM_W-1:0] div16_tz(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] biased;
        biased = s[SUM_W-1] ? (s + SUM_W'(15)) : s;
        return biased >>> 4;
    endfunction

    // Add bias and keep the low W_W bits (two's-complement wrap, no saturation)
    function automatic logic signed [W_W-1:0] wrap_y(input logic signed [SUM_W-1:0] q,
                                                     input logic signed [W_W-1:0]   b);
        logic signed [SUM_W-1:0] full;
        full = q + SUM_W'(b);
        return full[W_W-1:0];
    endfunction

    logic signed [W_W-1:0]    w1_r;
    logic signed [W_W-1:0]    w2_r;
    logic signed [W_W-1:0]    b_r;

    logic                     vld_p1;
    logic                     vld_p2;
    stage_vld_t               vld;
    logic                     s1_adv;
    logic                     in_hs;
    logic                     out_hs;

    logic signed [PROD_W-1:0] prod1_p1;
    logic signed [PROD_W-1:0] prod2_p1;
    logic signed [W_W-1:0]    b_p1;
    logic signed [T_W-1:0]    t_p1;

    logic signed [W_W-1:0]    y_nxt;

    assign vld      = {vld_p2, vld_p1};
    assign busy     = |vld;
    assign outValid = vld_p2;

    // Stage 1 may move forward when the output register is empty or being drained now
    assign s1_adv   = !vld_p2 || outReady;
    assign inReady  = !rst && !ldWeights && (!vld_p1 || s1_adv);
    assign in_hs    = inValid && inReady;
    assign out_hs   = !rst && vld_p2 && outReady;

    assign y_nxt    = wrap_y(div16_tz(SUM_W'(prod1_p1) + SUM_W'(prod2_p1)), b_p1);

    // Trained weight/bias registers
    always_ff @(posedge clk) begin
        if (rst) begin
            w1_r <= '0;
            w2_r <= '0;
            b_r  <= '0;
        end else if (ldWeights) begin
            w1_r <= w1In;
            w2_r <= w2In;
            b_r  <= bIn;
        end
    end

    // Stage occupancy: stage 1 refills on accept, stage 2 takes stage 1 whenever it may advance
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (!vld_p1 || s1_adv) begin
                vld_p1 <= in_hs;
            end
            if (s1_adv) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- stage 1: products, plus the bias and label in force at accept time ----
    // Capture products and the per-sample context on input handshake
    always_ff @(posedge clk) begin
        if (in_hs) begin
            prod1_p1 <= PROD_W'(w1_r) * PROD_W'(x1);
            prod2_p1 <= PROD_W'(w2_r) * PROD_W'(x2);
            b_p1     <= b_r;
            t_p1     <= t;
        end
    end

    // ---- stage 2: sum, scale, bias, classify ----
    // Output register: loads only when stage 1 advances, so it holds steady under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= '0;
            cls      <= '0;
            mismatch <= 1'b0;
        end else if (vld_p1 && s1_adv) begin
            y        <= y_nxt;
            cls      <= y_nxt[W_W-1] ? NEG : POS;
            mismatch <= (y_nxt[W_W-1] != t_p1[T_W-1]);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cntClear),
        .inc (out_hs),
        .cnt (sampleCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cntClear),
        .inc (out_hs && mismatch),
        .cnt (errorCount)
    );

endmodule

// File: tb/tb_neuron_classifier.sv
// Directed bench for neuron_classifier with a queue-based reference model checked every cycle.
module tb_neuron_classifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        ldWeights;
    logic [13:0] w1In, w2In, bIn;
    logic        cntClear;
    logic        inValid;
    logic        inReady;
    logic [6:0]  x1, x2;
    logic [1:0]  t;
    logic        outValid;
    logic        outReady;
    logic [13:0] y;
    logic [1:0]  cls;
    logic        mismatch;
    logic [15:0] sampleCount, errorCount;
    logic        busy;

    always #5 clk = ~clk;

    neuron_classifier #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ldWeights   (ldWeights),
        .w1In        (w1In),
        .w2In        (w2In),
        .bIn         (bIn),
        .cntClear    (cntClear),
        .inValid     (inValid),
        .inReady     (inReady),
        .x1          (x1),
        .x2          (x2),
        .t           (t),
        .outValid    (outValid),
        .outReady    (outReady),
        .y           (y),
        .cls         (cls),
        .mismatch    (mismatch),
        .sampleCount (sampleCount),
        .errorCount  (errorCount),
        .busy        (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: integer division in SV already truncates toward zero
    function automatic logic [13:0] ref_y(input int w1, input int w2, input int b,
                                          input int a1, input int a2);
        int s;
        int q;
        s = w1 * a1 + w2 * a2;
        q = s / 16;
        return 14'(q + b);
    endfunction

    typedef struct packed {
        logic [13:0] y;
        logic        t1;
    } exp_t;

    exp_t q_exp[$];
    int   mw1 = 0, mw2 = 0, mb = 0;
    int   mcnt = 0, merr = 0;

    exp_t m_e;
    logic m_in_hs, m_out_hs, m_mm, m_rdy;

    // Compare DUT against the model mid-cycle, then advance the model by the coming edge
    always @(negedge clk) begin
        m_rdy = !rst && !ldWeights && ((q_exp.size() < 2) || outReady);
        chk("inReady", inReady, m_rdy);
        chk("busy", busy, q_exp.size() != 0);
        chk("sampleCount", sampleCount, mcnt);
        chk("errorCount", errorCount, merr);
        if (outValid) begin
            chk("outValid_has_entry", q_exp.size() > 0, 1);
            if (q_exp.size() > 0) begin
                m_e = q_exp[0];
                chk("y", y, m_e.y);
                chk("cls", cls, m_e.y[13] ? 2'b11 : 2'b01);
                chk("mismatch", mismatch, m_e.y[13] != m_e.t1);
            end
        end

        if (rst) begin
            q_exp.delete();
            mw1 = 0; mw2 = 0; mb = 0;
            mcnt = 0; merr = 0;
        end else begin
            m_out_hs = outValid && outReady;
            m_in_hs  = inValid && inReady;
            m_mm     = 1'b0;
            if (m_out_hs && q_exp.size() > 0) begin
                m_e  = q_exp.pop_front();
                m_mm = (m_e.y[13] != m_e.t1);
            end
            if (cntClear) begin
                mcnt = 0;
                merr = 0;
            end else if (m_out_hs) begin
                if (mcnt < 65535) mcnt++;
                if (m_mm && merr < 65535) merr++;
            end
            if (m_in_hs) begin
                m_e.y  = ref_y(mw1, mw2, mb, $signed(x1), $signed(x2));
                m_e.t1 = t[1];
                q_exp.push_back(m_e);
            end
            if (ldWeights) begin
                mw1 = $signed(w1In);
                mw2 = $signed(w2In);
                mb  = $signed(bIn);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int w1, input int w2, input int b);
        ldWeights = 1'b1;
        w1In = 14'(w1);
        w2In = 14'(w2);
        bIn  = 14'(b);
        tick;
        ldWeights = 1'b0;
    endtask

    task automatic push(input int a1, input int a2, input logic [1:0] lbl);
        logic ok;
        inValid = 1'b1;
        x1 = 7'(a1);
        x2 = 7'(a2);
        t  = lbl;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = inReady;
            tick;
        end
        inValid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic expect_out(input string name, input logic [13:0] ey,
                              input logic [1:0] ec, input logic em);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (outValid) begin
                found = 1'b1;
                chk({name, "_y"}, y, ey);
                chk({name, "_cls"}, cls, ec);
                chk({name, "_mismatch"}, mismatch, em);
            end
            tick;
        end
        chk({name, "_seen"}, found, 1);
    endtask

    int   acc, got, first, last;
    logic hs;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ldWeights = 1'b0; w1In = '0; w2In = '0; bIn = '0;
        cntClear = 1'b0; inValid = 1'b0; x1 = '0; x2 = '0; t = 2'b01; outReady = 1'b0;

        // Pin the reference arithmetic to hand-computed values
        chk("model_trunc15", ref_y(1, 0, 0, -15, 0), 14'h0000);
        chk("model_trunc16", ref_y(1, 0, 0, -16, 0), 14'h3FFF);
        chk("model_neg", ref_y(16, 16, -3, -5, 0), 14'h3FF8);

        // Reset state
        repeat (2) tick;
        @(negedge clk);
        chk("rst_inReady", inReady, 0);
        chk("rst_outValid", outValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", y, 0);
        chk("rst_cls", cls, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_sampleCount", sampleCount, 0);
        chk("rst_errorCount", errorCount, 0);
        tick;
        rst = 1'b0;

        // Basic positive with latency check
        outReady = 1'b1;
        load_w(16, 0, 0);
        push(5, 0, 2'b01);
        @(negedge clk);
        chk("lat_n1_outValid", outValid, 0);
        tick;
        @(negedge clk);
        chk("lat_n2_outValid", outValid, 1);
        chk("basic_y", y, 14'd5);
        chk("basic_cls", cls, 2'b01);
        chk("basic_mismatch", mismatch, 0);
        tick;
        @(negedge clk);
        chk("basic_sampleCount", sampleCount, 1);
        tick;

        // Negative output with label mismatch
        load_w(16, 16, -3);
        push(-5, 0, 2'b01);
        expect_out("neg", 14'h3FF8, 2'b11, 1'b1);
        @(negedge clk);
        chk("neg_errorCount", errorCount, 1);
        chk("neg_sampleCount", sampleCount, 2);
        tick;

        // Division truncates toward zero
        load_w(1, 0, 0);
        push(-15, 0, 2'b01);
        expect_out("trunc15", 14'h0000, 2'b01, 1'b0);
        push(-16, 0, 2'b01);
        expect_out("trunc16", 14'h3FFF, 2'b11, 1'b1);

        // Backpressure: three offered, two held, output stable, then in-order drain
        load_w(16, 0, 0);
        outReady = 1'b0;
        inValid = 1'b1; x1 = 7'd1; x2 = '0; t = 2'b01;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hs = inReady;
            tick;
            if (hs) begin
                acc++;
                x1 = 7'(acc + 1);
            end
        end
        chk("bp_accepted", acc, 2);
        @(negedge clk);
        chk("bp_inReady", inReady, 0);
        chk("bp_outValid", outValid, 1);
        chk("bp_y_first", y, 14'd1);
        repeat (3) begin
            tick;
            @(negedge clk);
            chk("bp_y_stable", y, 14'd1);
        end
        tick;
        outReady = 1'b1;
        got = 0; first = 0; last = 0;
        for (int i = 0; i < 10 && got < 3; i++) begin
            @(negedge clk);
            if (outValid) begin
                chk("bp_drain_y", y, 14'(got + 1));
                if (got == 0) first = i;
                last = i;
                got++;
            end
            hs = inValid && inReady;
            tick;
            if (hs) inValid = 1'b0;
        end
        inValid = 1'b0;
        chk("bp_drain_count", got, 3);
        chk("bp_drain_back_to_back", last - first, 2);

        // Weight change between two in-flight samples
        outReady = 1'b0;
        load_w(16, 0, 0);
        push(2, 0, 2'b01);
        ldWeights = 1'b1; w1In = 14'd32; w2In = '0; bIn = '0;
        inValid = 1'b1; x1 = 7'd2;
        @(negedge clk);
        chk("ld_inReady", inReady, 0);
        tick;
        ldWeights = 1'b0;
        push(2, 0, 2'b01);
        outReady = 1'b1;
        expect_out("wchg_A", 14'd2, 2'b01, 1'b0);
        expect_out("wchg_B", 14'd4, 2'b01, 1'b0);

        // Reset with two samples in flight
        outReady = 1'b0;
        push(1, 0, 2'b01);
        push(2, 0, 2'b01);
        @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        chk("midrst_count_before", sampleCount != 0, 1);
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        chk("midrst_outValid", outValid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sampleCount", sampleCount, 0);
        chk("midrst_errorCount", errorCount, 0);
        tick;
        rst = 1'b0;

        // Weights were cleared by reset
        outReady = 1'b1;
        push(5, 3, 2'b01);
        expect_out("zero_w", 14'd0, 2'b01, 1'b0);

        // Counter clear coincident with an output handshake
        load_w(32, 0, 0);
        outReady = 1'b0;
        push(1, 0, 2'b01);
        tick;
        @(negedge clk);
        chk("clr_hold_valid", outValid, 1);
        chk("clr_count_before", sampleCount, 1);
        tick;
        cntClear = 1'b1;
        outReady = 1'b1;
        tick;
        cntClear = 1'b0;
        @(negedge clk);
        chk("clr_outValid", outValid, 0);
        chk("clr_sampleCount", sampleCount, 0);
        chk("clr_errorCount", errorCount, 0);
        tick;

        // Saturation: drive both counters to all-ones, then one more handshake
        load_w(16, 0, 0);
        outReady = 1'b1;
        inValid = 1'b1; x1 = 7'd1; x2 = '0; t = 2'b11;
        repeat (65535) tick;
        inValid = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("sat_sampleCount_max", sampleCount, 16'hFFFF);
        chk("sat_errorCount_max", errorCount, 16'hFFFF);
        tick;
        push(1, 0, 2'b11);
        expect_out("sat_extra", 14'd1, 2'b01, 1'b1);
        @(negedge clk);
        chk("sat_sampleCount_hold", sampleCount, 16'hFFFF);
        chk("sat_errorCount_hold", errorCount, 16'hFFFF);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_classifier.md
# neuron_classifier

Inference-side counterpart of the perceptron training datapath: consumes the trained weights `w1`, `w2`, `b` and classifies a stream of samples. It evaluates the training datapath's output function y = (w1·x1 + w2·x2)/16 + b and returns the class sign. When a label is supplied, it also flags and counts misclassifications. It sits after training completes, between the sample source and the result sink, with valid/ready handshakes on both sides.

## Interface
- `CNT_W`, 16, width of the sample and error counters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ldWeights`  in  1  capture `w1In`/`w2In`/`bIn` at this edge.
- `w1In`, `w2In`, `bIn`  in  14 each  signed trained weights and bias.
- `cntClear`  in  1  zero both counters.
- `inValid`  in  1  sample offered.
- `inReady`  out  1  sample accepted when `inValid && inReady`.
- `x1`, `x2`  in  7 each  signed sample features.
- `t`  in  2  signed label; +1 = 2'b01, −1 = 2'b11.
- `outValid`  out  1  result available.
- `outReady`  in  1  sink accepts the result when `outValid && outReady`.
- `y`  out  14  signed neuron output.
- `cls`  out  2  signed class: 2'b01 if y[13]==0, otherwise 2'b11.
- `mismatch`  out  1  asserted when y[13] != t[1].
- `sampleCount`, `errorCount`  out  CNT_W  saturating counters.
- `busy`  out  1  asserted when either pipeline stage holds a valid entry.

## Operation
- **Weight registers**
  - Loaded from `w1In`/`w2In`/`bIn` on an edge where `ldWeights=1`.
  - `inReady` is forced to 0 in any cycle with `ldWeights=1`.
- **Stage 1**, on accept:
  - Registers p1 = w1·x1 and p2 = w2·x2, each 21-bit signed.
  - Also registers the current b and t, so every in-flight sample completes with the weights that were in force when it was accepted.
- **Stage 2**, output register:
  - Forms s = p1 + p2 as 22-bit signed.
  - Forms q = s/16 with signed division truncating toward zero. Examples: −15/16 = 0, −80/16 = −5.
  - y = q + b, truncated to 14 bits. Two's-complement wrap, no saturation.
  - `cls` and `mismatch` are derived from y and the carried t.
- **Flow control**
  - Each stage advances when the stage downstream of it is empty or is being consumed in the same cycle.
  - `inReady = !rst && !ldWeights && (!s1Valid || s1Advance)`.
  - Full throughput is one sample per clock when `outReady` is held at 1.
- **Counters**, updated on an output handshake:
  - `sampleCount` increments.
  - `errorCount` increments if `mismatch=1`.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - `cntClear` takes priority over a same-cycle increment, giving result 0.
- **Output stability:** `y`, `cls` and `mismatch` stay stable while `outValid && !outReady`.

## Timing
- **Reset values:** all outputs are 0, including `inReady`, `outValid`, `busy`, `y`, `cls`, `mismatch` and both counters; weights are 0.
- **Reset mid-operation:** `rst` discards both stages at the next edge. No handshake completes in a reset cycle.
- **Latency:** a sample accepted in cycle N gives `outValid=1` in cycle N+2 if not stalled.
- **Stall:** with `outReady=0`, the pipeline holds at most 2 samples. `inReady` falls in the cycle after the second sample is accepted.
- **Stall release:** an output handshake with stage 1 full lets stage 1 move to stage 2 and a new sample enter in the same cycle.
- **`ldWeights` during a stall:** legal. It affects only samples accepted afterwards.
- **`busy`:** 0 only when both stages are empty.

## Structure
- **Package `neuron_pkg`** holds:
  - Widths X_W=7, W_W=14, T_W=2, PROD_W=21, SUM_W=22.
  - Label and class constants POS=2'b01 and NEG=2'b11.
  - The shared 2-entry stage-valid typedef.
- **Sub-module `sat_counter`:** CNT_W-bit, with sync clear, increment-enable and saturation. Instantiated twice.
- The datapath and handshake stay in `neuron_classifier`.

## Test plan
- **Basic positive:** w1=16, w2=0, b=0; x1=5, t=+1, outReady=1 → in cycle N+2, y=5, cls=01, mismatch=0, sampleCount=1.
- **Negative with mismatch:** w1=16, w2=16, b=−3 (14'h3FFD); x1=−5, x2=0, t=+1 → y=−8, cls=11, mismatch=1, errorCount=1.
- **Truncation toward zero:** w1=1, w2=0, b=0; x1=−15 → y=0, cls=01. Also x1=−16 → y=−1.
- **Backpressure:** hold outReady=0 and stream 3 samples → exactly 2 accepted, inReady=0, y held stable. Raising outReady drains all results in order, one per cycle.
- **Mid-stream weight change:** load w1=16 and accept sample A (x1=2), then load w1=32 and accept sample B (x1=2) → y_A=2, y_B=4. inReady=0 in the ldWeights cycle.
- **Reset and counter edges:**
  - Assert rst with 2 samples in flight → next cycle outValid=0, busy=0, counters=0.
  - Force sampleCount to 16'hFFFF → the next handshake keeps it at 16'hFFFF.
  - cntClear coincident with a handshake → counters=0.
